// File: rtl/npc_lsu.sv
// Load/store unit between EXU and WBU: one memory operation in flight, byte/half/word
// access with lane steering, load extension, alignment checks and a request timeout.
module npc_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [DATA_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic [4:0]              in_rd,
  output logic                    mem_valid,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_wmask,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_rdata,
  output logic [4:0]              out_rd,
  output logic                    out_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                  state, state_nx;
  logic [3:0]              op_q;
  logic [DATA_WIDTH-1:0]   addr_q, wdata_q, rdata_q;
  logic [4:0]              rd_q;
  logic                    err_q;
  logic [15:0]             cnt;
  logic                    accept, bad, timeout_hit;
  logic [DATA_WIDTH-1:0]   lane, load_data;

  // Illegal opcode or access not aligned to its size.
  function automatic logic is_bad(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      4'b0000, 4'b0100, 4'b1000: is_bad = 1'b0;
      4'b0001, 4'b0101, 4'b1001: is_bad = lo[0];
      4'b0010, 4'b1010:          is_bad = |lo;
      default:                   is_bad = 1'b1;
    endcase
  endfunction

  assign accept      = in_valid & in_ready;
  assign bad         = is_bad(in_op, in_addr[1:0]);
  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = bad ? RESP : REQ;
      REQ:     if (mem_ready || timeout_hit) state_nx = RESP;
      RESP:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (op_q[2:0])
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= in_op;
          addr_q  <= in_addr;
          wdata_q <= in_wdata;
          rd_q    <= in_rd;
          rdata_q <= '0;
          err_q   <= bad;
          cnt     <= '0;
        end
        REQ: begin
          // A completing memory response wins over a timeout in the same cycle.
          if (mem_ready) begin
            rdata_q <= op_q[3] ? '0 : load_data;
          end else begin
            cnt <= cnt + 16'd1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        RESP: if (out_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_wmask = 4'b0000;
    if (op_q[3]) begin
      case (op_q[1:0])
        2'b00:   mem_wmask = 4'b0001 << addr_q[1:0];
        2'b01:   mem_wmask = 4'b0011 << addr_q[1:0];
        default: mem_wmask = 4'b1111;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign mem_valid = (state == REQ);
  assign out_valid = (state == RESP);
  assign mem_wen   = op_q[3];
  assign mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign out_rdata = rdata_q;
  assign out_rd    = rd_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_npc_lsu.sv
// Scoreboard bench for npc_lsu: a reference model queues expected memory requests and
// results at accept time; a negedge monitor plays memory/WBU and compares against them.
module tb_npc_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;

  npc_lsu #(.DATA_WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mask;
    int          nreq;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          mem_lat = 0;
  int          out_lat = 0;
  int          req_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] mem_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder and WBU sink, both sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_cnt = 0; resp_cnt = 0; mem_ready = 1'b0; out_ready = 1'b0;
    end else begin
      if (mem_valid) begin
        req_cnt++;
        if (sb.size() == 0) check("mem_unexpected", 32'(sb.size()), 32'd1);
        else begin
          check("mem_wen", 32'(mem_wen), 32'(sb[0].wen));
          check("mem_addr", mem_addr, sb[0].maddr);
          check("mem_wmask", 32'(mem_wmask), 32'(sb[0].mask));
          if (sb[0].wen) check("mem_wdata", mem_wdata, sb[0].mwdata);
        end
        mem_ready = (req_cnt > mem_lat);
        mem_rdata = mem_ready ? mem_word : 32'hDEAD_BEEF;
      end else mem_ready = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) check("out_unexpected", 32'(sb.size()), 32'd1);
        else begin
          if (resp_cnt == 0) begin
            check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
            check("req_cycles", 32'(req_cnt), 32'(sb[0].nreq));
          end
          check("out_rdata", out_rdata, sb[0].rdata);
          check("out_rd", 32'(out_rd), 32'(sb[0].rd));
          check("out_err", 32'(out_err), 32'(sb[0].err));
          check("in_ready_resp", 32'(in_ready), 32'd0);
          resp_cnt++;
          if (resp_cnt > out_lat) begin
            out_ready = 1'b1;
            void'(sb.pop_front());
          end
        end
      end else begin
        out_ready = 1'b0;
        resp_cnt = 0;
      end
      if (in_ready) req_cnt = 0;
    end
  end

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic [31:0] word, input int mlat);
    exp_t e;
    int   off;
    logic pre_err;
    off = int'(addr[1:0]);
    e.rd = rd; e.wen = op[3]; e.maddr = addr & 32'hFFFF_FFFC;
    e.mwdata = wdata << (8 * off); e.mask = 4'b0000; e.rdata = '0;
    case (op)
      4'b0000: begin pre_err = 1'b0;     e.rdata = 32'($signed(word[8*off +: 8])); end
      4'b0100: begin pre_err = 1'b0;     e.rdata = {24'h0, word[8*off +: 8]}; end
      4'b0001: begin pre_err = addr[0];  if (!pre_err) e.rdata = 32'($signed(word[8*off +: 16])); end
      4'b0101: begin pre_err = addr[0];  if (!pre_err) e.rdata = {16'h0, word[8*off +: 16]}; end
      4'b0010: begin pre_err = |addr[1:0]; e.rdata = word; end
      4'b1000: begin pre_err = 1'b0;     e.mask[off] = 1'b1; end
      4'b1001: begin pre_err = addr[0];  if (!pre_err) begin e.mask[off] = 1'b1; e.mask[off+1] = 1'b1; end end
      4'b1010: begin pre_err = |addr[1:0]; e.mask = 4'b1111; end
      default: pre_err = 1'b1;
    endcase
    e.nreq = pre_err ? 0 : (mlat >= 255 ? 255 : mlat + 1);
    e.err  = pre_err || (mlat >= 255);
    if (e.err) e.rdata = '0;
    e.lat  = pre_err ? 1 : e.nreq + 1;
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] word, input int mlat, input int olat);
    exp_t e;
    e = model(op, addr, wdata, rd, word, mlat);
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    check("in_ready_wait", 32'(in_ready), 32'd1);
    mem_word = word; mem_lat = mlat; out_lat = olat;
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
    @(posedge clk);
    acc_cyc = cyc;
    sb.push_back(e);
    #1;
    in_valid = 1'b0; in_op = 4'b1111; in_addr = 32'hFFFF_FFFF; in_wdata = 32'h5555_5555; in_rd = 5'h1F;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk);
    check("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input logic [31:0] word, input int mlat, input int olat);
    issue(op, addr, wdata, rd, word, mlat, olat);
    wait_done();
  endtask

  logic [3:0] ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                          4'b1000, 4'b1001, 4'b1010, 4'b0011};

  initial begin
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    do_op(4'b0000, 32'h8000_0003, 32'h0,        5'd1,  32'h80FF_1234, 0, 0);  // LB sign
    do_op(4'b1001, 32'h8000_0002, 32'h0000_ABCD, 5'd2, 32'h0,         0, 0);  // SH upper half
    do_op(4'b0010, 32'h8000_0001, 32'h0,        5'd3,  32'h1111_2222, 0, 0);  // LW misaligned
    do_op(4'b0001, 32'h8000_0002, 32'h0,        5'd4,  32'h8001_0000, 1, 0);  // LH sign
    do_op(4'b0101, 32'h8000_0002, 32'h0,        5'd5,  32'h8001_0000, 0, 1);  // LHU zero
    do_op(4'b0100, 32'h8000_0001, 32'h0,        5'd6,  32'h0000_F200, 2, 0);  // LBU
    do_op(4'b0010, 32'h8000_0010, 32'h0,        5'd7,  32'h1234_5678, 3, 0);  // LW
    do_op(4'b1000, 32'h8000_0001, 32'h0000_005A, 5'd8, 32'h0,         0, 0);  // SB
    do_op(4'b1010, 32'h8000_0004, 32'hCAFE_F00D, 5'd9, 32'h0,         1, 0);  // SW
    do_op(4'b0011, 32'h8000_0000, 32'h0,        5'd10, 32'h0,         0, 0);  // illegal
    do_op(4'b1001, 32'h8000_0003, 32'h0000_1234, 5'd11, 32'h0,        0, 0);  // SH odd
    do_op(4'b0001, 32'h8000_0001, 32'h0,        5'd12, 32'hFFFF_FFFF, 0, 0);  // LH odd
    do_op(4'b0010, 32'h8000_0020, 32'h0,        5'd13, 32'hA5A5_5A5A, 0, 5);  // out_ready stall
    do_op(4'b0101, 32'h8000_0000, 32'h0,        5'd14, 32'h0000_7777, 1000, 0); // timeout
    do_op(4'b0000, 32'h8000_0000, 32'h0,        5'd15, 32'h0000_007F, 254, 0); // ready on last cycle

    for (int k = 0; k < 12; k++)
      do_op(ops[$urandom_range(0, 8)], 32'h8000_0000 | 32'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3), $urandom_range(0, 2));

    // Reset in the middle of a pending request.
    issue(4'b0010, 32'h8000_0040, 32'h0, 5'd16, 32'h0BAD_0BAD, 50, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_valid", 32'(mem_valid), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_err", 32'(out_err), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    do_op(4'b0010, 32'h8000_0044, 32'h0, 5'd17, 32'h600D_600D, 0, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=0", sb.size());
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/npc_lsu.md
NPC_LSU -- requirements
Module: npc_lsu

Interface
REQ-001 Parameter DATA_WIDTH, 32, data and address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, 255, maximum number of REQ cycles before the access is aborted with an error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  EXU presents a memory operation.
REQ-006 in_ready  output  1  LSU accepts an operation; high only in IDLE.
REQ-007 in_op  input  4  operation: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes are illegal.
REQ-008 in_addr  input  32  byte address.
REQ-009 in_wdata  input  32  store data, right-aligned.
REQ-010 in_rd  input  5  destination tag; passed through to out_rd.
REQ-011 mem_valid  output  1  memory request strobe.
REQ-012 mem_wen  output  1  request is a store.
REQ-013 mem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-014 mem_wdata  output  32  store data shifted into lane position.
REQ-015 mem_wmask  output  4  byte-lane write enables.
REQ-016 mem_ready  input  1  memory completes the request this cycle.
REQ-017 mem_rdata  input  32  read word; valid when mem_ready is high.
REQ-018 out_valid  output  1  result available to WBU.
REQ-019 out_ready  input  1  WBU consumes the result.
REQ-020 out_rdata  output  32  extended load data; 0 for stores and errors.
REQ-021 out_rd  output  5  registered copy of in_rd.
REQ-022 out_err  output  1  misaligned, illegal, or timed-out access.

Function
REQ-023 FSM states SHALL be IDLE, REQ, RESP; in_ready = (state==IDLE), mem_valid = (state==REQ), out_valid = (state==RESP).
REQ-024 An operation SHALL be accepted on a rising edge where in_valid & in_ready; op, addr, wdata and rd are registered at that edge.
REQ-025 An accepted operation SHALL go IDLE->RESP with out_err=1 and no memory request if the op is illegal, LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]!=0; otherwise it SHALL go IDLE->REQ.
REQ-026 In REQ, mem_wen, mem_addr, mem_wdata and mem_wmask SHALL be held stable until mem_ready is sampled high.
REQ-027 REQ->RESP SHALL occur on the edge where mem_ready=1; loads capture mem_rdata at that edge.
REQ-028 A 16-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ready; on reaching TIMEOUT, the block SHALL go REQ->RESP with out_err=1 and out_rdata=0.
REQ-029 RESP->IDLE SHALL occur on the edge where out_ready=1; outputs hold while out_ready=0.
REQ-030 Store masks: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; mem_wdata = in_wdata<<(8*addr[1:0]).
REQ-031 Loads SHALL select byte/half at offset 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
REQ-032 Load mem_wmask SHALL be 4'b0000 with mem_wen=0.
REQ-033 Minimum latency SHALL be 2 cycles from the accept edge to out_valid (mem_ready high in the first REQ cycle); an error is reported 1 cycle after the accept edge.
REQ-034 Back-to-back operation: a new op is accepted only in the cycle after the RESP handshake, so throughput is at most 1 op per 3 cycles.

Reset
REQ-035 While rst_n=0: state=IDLE, counter=0, registered op/addr/wdata/rd/rdata=0; hence in_ready=1 and mem_valid=out_valid=out_err=0.
REQ-036 Asserting reset in REQ or RESP SHALL abort the operation immediately: mem_valid and out_valid drop without waiting for a clock edge, and no result is produced.

Verification
V-1 LB addr=0x80000003 with mem_rdata=0x80FF_1234 and mem_ready high in the first REQ cycle -> out_rdata=0xFFFF_FF80, out_err=0, out_valid 2 cycles after accept.
V-2 SH addr=0x80000002, wdata=0x0000_ABCD -> mem_wmask=4'b1100, mem_wdata=0xABCD_0000, mem_addr=0x80000000, mem_wen=1.
V-3 LW addr=0x80000001 -> mem_valid never asserted; out_err=1, out_rdata=0 one cycle after accept.
V-4 LHU with mem_ready held low for 255 cycles -> out_err=1 via timeout, mem_valid deasserts, FSM returns to IDLE after out_ready.
V-5 out_ready held low for 5 cycles in RESP -> out_valid, out_rdata and out_rd stable throughout; in_ready=0 until the handshake completes.
V-6 rst_n pulsed low mid-REQ -> mem_valid=0 asynchronously; after release in_ready=1 and the next op completes normally.
